// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_df.sv
// One-bit dataflow full adder; the only arithmetic element in the serial datapath.
module full_adder_df (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: a+b+cin computed LSB first through a single full-adder slice,
// one bit per RUN cycle, result registered on entry to DONE.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, p_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co;
   logic             last_bit;

   full_adder_df u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit = (state == RUN) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // The final slice output is folded straight into sum so the result lands on the DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         p_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               p_sh  <= {fa_s, p_sh[WIDTH-1:1]};
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  sum  <= {fa_s, p_sh[WIDTH-1:1]};
                  cout <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
